// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD status pager.
// Holds the character type, the ASCII constants used to build status lines,
// the nibble-to-hex-digit helper, and the render FSM state encoding.
package lcd_pkg;

  typedef logic [7:0] char_t;

  localparam char_t SPACE = 8'h20;
  localparam char_t DASH  = 8'h2D;
  localparam char_t COLON = 8'h3A;
  localparam char_t CHR_C = 8'h43;
  localparam char_t CHR_H = 8'h48;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_RENDER,
    ST_COMMIT
  } render_state_t;

  // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F' ('A' - 10 = 0x37).
  function automatic char_t hex2ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/lcd_char_gen.sv
// Combinational character generator for one status line.
// Produces the character at a given column of the line "CHk: VVVV   ...".
// Ports:
//   col     - column being rendered (0 = leftmost)
//   ch_idx  - channel number shown as one hex digit
//   value   - channel value, printed MSB nibble first
//   valid   - 0 replaces every value digit with '-'
//   blank   - 1 renders the whole line as spaces
//   chr     - resulting ASCII character
module lcd_char_gen
  import lcd_pkg::*;
#(
  parameter int LCD_COLS = 16,
  parameter int VAL_W    = 16
) (
  input  logic [$clog2(LCD_COLS)-1:0] col,
  input  logic [3:0]                  ch_idx,
  input  logic [VAL_W-1:0]            value,
  input  logic                        valid,
  input  logic                        blank,
  output char_t                       chr
);

  localparam int NDIG = VAL_W / 4;

  int col_i;
  int nib_base;

  // Label occupies columns 0-4, value digits follow, everything else is padding.
  always_comb begin
    chr      = SPACE;
    col_i    = int'(col);
    nib_base = 0;
    if (!blank) begin
      if (col_i == 0) begin
        chr = CHR_C;
      end else if (col_i == 1) begin
        chr = CHR_H;
      end else if (col_i == 2) begin
        chr = hex2ascii(ch_idx);
      end else if (col_i == 3) begin
        chr = COLON;
      end else if (col_i >= 5 && col_i < 5 + NDIG) begin
        // First value column shows the most significant nibble.
        nib_base = (NDIG - 1 - (col_i - 5)) * 4;
        chr      = valid ? hex2ascii(value[nib_base +: 4]) : DASH;
      end
    end
  end

endmodule

// File: rtl/lcd_status_pager.sv
// Formats NUM_CH live hex status values into two LCD line buffers, two
// channels per page, paging automatically every PAGE_HOLD cycles or on
// page_next. Each frame is rendered one character per cycle into shadow
// buffers and copied to the outputs in a single cycle, so the display
// controller never sees a half-written frame.
// Ports:
//   clk_50mhz, rst            - clock, synchronous active-high reset
//   ch_values, ch_valid       - flat channel values and per-channel valid bits
//   freeze                    - stops auto paging and periodic refresh
//   page_next                 - one-cycle pulse, advance one page
//   line1_buffer/line2_buffer - line contents, leftmost character at MSBs
//   page_idx                  - current page
//   busy                      - high while a frame is being produced
//   frame_done                - one-cycle pulse when the line buffers update
module lcd_status_pager
  import lcd_pkg::*;
#(
  parameter int LCD_COLS    = 16,
  parameter int NUM_CH      = 8,
  parameter int VAL_W       = 16,
  parameter int PAGE_HOLD   = 50_000_000,
  parameter int REFRESH_CYC = 5_000_000
) (
  input  logic                              clk_50mhz,
  input  logic                              rst,
  input  logic [NUM_CH*VAL_W-1:0]           ch_values,
  input  logic [NUM_CH-1:0]                 ch_valid,
  input  logic                              freeze,
  input  logic                              page_next,
  output logic [8*LCD_COLS-1:0]             line1_buffer,
  output logic [8*LCD_COLS-1:0]             line2_buffer,
  output logic [$clog2((NUM_CH+1)/2):0]     page_idx,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int NUM_PAGES = (NUM_CH + 1) / 2;
  localparam int PW        = $clog2(NUM_PAGES) + 1;
  localparam int CW        = $clog2(LCD_COLS);
  localparam int RCW       = $clog2(2 * LCD_COLS);
  localparam int HOLD_W    = $clog2(PAGE_HOLD + 1);
  localparam int REF_W     = $clog2(REFRESH_CYC + 1);
  localparam int LINE_W    = 8 * LCD_COLS;

  render_state_t     state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REF_W-1:0]  refresh_cnt;
  logic              render_pending;
  logic              hold_hit, refresh_hit, advance;
  logic [RCW-1:0]    rcnt;

  logic [3:0]        snap_idx0, snap_idx1;
  logic [VAL_W-1:0]  snap_val0, snap_val1;
  logic              snap_valid0, snap_valid1, snap_blank1;
  logic [LINE_W-1:0] shadow1, shadow2;

  int                lo_ch, hi_ch;
  int                render_col_i;
  logic              render_line2;
  logic [CW-1:0]     gen_col;
  logic [3:0]        gen_idx;
  logic [VAL_W-1:0]  gen_val;
  logic              gen_valid, gen_blank;
  char_t             gen_chr;

  // Trigger decode; a page_next landing on hold expiry still moves one page.
  always_comb begin
    hold_hit    = !freeze && (hold_cnt == HOLD_W'(PAGE_HOLD - 1));
    refresh_hit = !freeze && (refresh_cnt == REF_W'(REFRESH_CYC - 1));
    advance     = page_next || hold_hit;
  end

  // Page/refresh timers and the pending-render flag. A new trigger wins over
  // the clear in IDLE so no request is ever lost; repeats while busy coalesce.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      hold_cnt       <= '0;
      refresh_cnt    <= '0;
      page_idx       <= '0;
      render_pending <= 1'b1;
    end else begin
      if (advance)      hold_cnt <= '0;
      else if (!freeze) hold_cnt <= hold_cnt + HOLD_W'(1);

      if (refresh_hit)  refresh_cnt <= '0;
      else if (!freeze) refresh_cnt <= refresh_cnt + REF_W'(1);

      if (advance)
        page_idx <= (page_idx == PW'(NUM_PAGES - 1)) ? '0 : page_idx + PW'(1);

      if (advance || refresh_hit)     render_pending <= 1'b1;
      else if (state_q == ST_IDLE)    render_pending <= 1'b0;
    end
  end

  // Render sequencing: one latch cycle, two full lines of characters, commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (render_pending) state_d = ST_LATCH;
      ST_LATCH:  state_d = ST_RENDER;
      ST_RENDER: if (rcnt == RCW'(2 * LCD_COLS - 1)) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // Channel selection for the page being latched and the character position
  // being rendered; the second line starts once the first is complete.
  always_comb begin
    lo_ch        = 2 * int'(page_idx);
    hi_ch        = lo_ch + 1;
    render_line2 = (int'(rcnt) >= LCD_COLS);
    render_col_i = render_line2 ? int'(rcnt) - LCD_COLS : int'(rcnt);
    gen_col      = CW'(render_col_i);
    gen_idx      = render_line2 ? snap_idx1   : snap_idx0;
    gen_val      = render_line2 ? snap_val1   : snap_val0;
    gen_valid    = render_line2 ? snap_valid1 : snap_valid0;
    gen_blank    = render_line2 ? snap_blank1 : 1'b0;
  end

  lcd_char_gen #(
    .LCD_COLS (LCD_COLS),
    .VAL_W    (VAL_W)
  ) u_char_gen (
    .col    (gen_col),
    .ch_idx (gen_idx),
    .value  (gen_val),
    .valid  (gen_valid),
    .blank  (gen_blank),
    .chr    (gen_chr)
  );

  // Snapshot, shadow fill and commit. Inputs are only sampled in LATCH so a
  // frame is internally consistent even if the values move mid-render.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rcnt         <= '0;
      snap_idx0    <= '0;
      snap_idx1    <= '0;
      snap_val0    <= '0;
      snap_val1    <= '0;
      snap_valid0  <= 1'b0;
      snap_valid1  <= 1'b0;
      snap_blank1  <= 1'b1;
      shadow1      <= {LCD_COLS{SPACE}};
      shadow2      <= {LCD_COLS{SPACE}};
      line1_buffer <= {LCD_COLS{SPACE}};
      line2_buffer <= {LCD_COLS{SPACE}};
      frame_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= (state_q == ST_COMMIT);
      case (state_q)
        ST_LATCH: begin
          rcnt        <= '0;
          snap_idx0   <= 4'(lo_ch);
          snap_idx1   <= 4'(hi_ch);
          snap_val0   <= ch_values[lo_ch*VAL_W +: VAL_W];
          snap_valid0 <= ch_valid[lo_ch];
          // An odd channel count leaves the last page's second line empty.
          if (hi_ch < NUM_CH) begin
            snap_val1   <= ch_values[hi_ch*VAL_W +: VAL_W];
            snap_valid1 <= ch_valid[hi_ch];
            snap_blank1 <= 1'b0;
          end else begin
            snap_val1   <= '0;
            snap_valid1 <= 1'b0;
            snap_blank1 <= 1'b1;
          end
        end
        ST_RENDER: begin
          rcnt <= rcnt + RCW'(1);
          if (render_line2) shadow2[(LCD_COLS-1-render_col_i)*8 +: 8] <= gen_chr;
          else              shadow1[(LCD_COLS-1-render_col_i)*8 +: 8] <= gen_chr;
        end
        ST_COMMIT: begin
          line1_buffer <= shadow1;
          line2_buffer <= shadow2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_status_pager.sv
// Self-checking bench for lcd_status_pager with five channels, short page
// hold and refresh periods. Table-driven page/format vectors plus directed
// sequences for startup, auto paging, snapshot/coalescing, freeze and reset
// during a render.
module tb_lcd_status_pager;

  localparam int LCD_COLS    = 16;
  localparam int NUM_CH      = 5;
  localparam int VAL_W       = 16;
  localparam int PAGE_HOLD   = 100;
  localparam int REFRESH_CYC = 60;
  localparam int PW          = 3;
  localparam logic [127:0] BLANK = {16{8'h20}};

  logic                      clk_50mhz = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_CH*VAL_W-1:0]   ch_values;
  logic [NUM_CH-1:0]         ch_valid;
  logic                      freeze;
  logic                      page_next;
  logic [8*LCD_COLS-1:0]     line1_buffer;
  logic [8*LCD_COLS-1:0]     line2_buffer;
  logic [PW-1:0]             page_idx;
  logic                      busy;
  logic                      frame_done;

  always #5 clk_50mhz = ~clk_50mhz;

  lcd_status_pager #(
    .LCD_COLS    (LCD_COLS),
    .NUM_CH      (NUM_CH),
    .VAL_W       (VAL_W),
    .PAGE_HOLD   (PAGE_HOLD),
    .REFRESH_CYC (REFRESH_CYC)
  ) dut (
    .clk_50mhz    (clk_50mhz),
    .rst          (rst),
    .ch_values    (ch_values),
    .ch_valid     (ch_valid),
    .freeze       (freeze),
    .page_next    (page_next),
    .line1_buffer (line1_buffer),
    .line2_buffer (line2_buffer),
    .page_idx     (page_idx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  typedef struct {
    logic [79:0]   vals;
    logic [4:0]    valid;
    logic [PW-1:0] page;
    logic [127:0]  l1;
    logic [127:0]  l2;
  } vec_t;

  vec_t vecs [6];
  int   checks   = 0;
  int   failures = 0;
  int   tb_cyc   = 0;

  // One clock step; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_50mhz);
    #1;
    tb_cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ch_values = v.vals;
    ch_valid  = v.valid;
    page_next = 1'b1;
    tick();
    page_next = 1'b0;
  endtask

  // Returns the number of steps until frame_done, or -1 if it never came.
  task automatic waitFrame(input int limit, output int took);
    took = -1;
    for (int i = 1; i <= limit && took < 0; i++) begin
      tick();
      if (frame_done) took = i;
    end
  endtask

  task automatic startFromReset();
    rst       = 1'b1;
    page_next = 1'b0;
    repeat (3) tick();
    rst    = 1'b0;
    tb_cyc = 0;
  endtask

  initial begin
    int took, first_fd, dirty, seen, fd_count;
    vecs[0] = '{{16'hC0DE, 16'h3333, 16'h2222, 16'h1234, 16'h9A5C}, 5'b11101, 3'd0,
                "CH0: 9A5C       ", "CH1: ----       "};
    vecs[1] = '{{16'hC0DE, 16'h0000, 16'hBEEF, 16'h1234, 16'h9A5C}, 5'b11111, 3'd1,
                "CH2: BEEF       ", "CH3: 0000       "};
    vecs[2] = '{{16'hF00D, 16'h0000, 16'hBEEF, 16'h1234, 16'h9A5C}, 5'b11111, 3'd2,
                "CH4: F00D       ", BLANK};
    vecs[3] = '{{16'hF00D, 16'h0000, 16'hBEEF, 16'hFFFF, 16'h0F0A}, 5'b11111, 3'd0,
                "CH0: 0F0A       ", "CH1: FFFF       "};
    vecs[4] = '{{16'hF00D, 16'h5A6B, 16'h8421, 16'hFFFF, 16'h0F0A}, 5'b10111, 3'd1,
                "CH2: 8421       ", "CH3: ----       "};
    vecs[5] = '{{16'hF00D, 16'h5A6B, 16'h8421, 16'hACE1, 16'h2468}, 5'b01111, 3'd2,
                "CH4: ----       ", BLANK};

    // Reset state
    ch_values = {16'hC0DE, 16'h5555, 16'h4444, 16'h00B3, 16'h1A2F};
    ch_valid  = 5'h1F;
    freeze    = 1'b0;
    page_next = 1'b0;
    rst       = 1'b1;
    repeat (3) tick();
    checkOutput("reset line1", line1_buffer, BLANK);
    checkOutput("reset line2", line2_buffer, BLANK);
    checkOutput("reset page_idx", page_idx, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset frame_done", frame_done, 0);

    // Startup frame without any trigger
    rst      = 1'b0;
    tb_cyc   = 0;
    first_fd = -1;
    dirty    = 0;
    if (line1_buffer !== BLANK || line2_buffer !== BLANK || frame_done) dirty = 1;
    for (int i = 1; i <= 40 && first_fd < 0; i++) begin
      tick();
      if (frame_done) first_fd = tb_cyc;
      else if (line1_buffer !== BLANK || line2_buffer !== BLANK) dirty = 1;
    end
    checkOutput("startup frame cycle", first_fd, 35);
    checkOutput("startup early change", dirty, 0);
    checkOutput("startup line1", line1_buffer, "CH0: 1A2F       ");
    checkOutput("startup line2", line2_buffer, "CH1: 00B3       ");
    tick();
    checkOutput("frame_done pulse width", frame_done, 0);

    // Auto paging and wrap
    seen = 0;
    while (tb_cyc < 300) begin
      tick();
      if (tb_cyc == 99)  checkOutput("page @99", page_idx, 0);
      if (tb_cyc == 100) checkOutput("page @100", page_idx, 1);
      if (tb_cyc == 199) checkOutput("page @199", page_idx, 1);
      if (tb_cyc == 200) checkOutput("page @200", page_idx, 2);
      if (tb_cyc == 299) checkOutput("page @299", page_idx, 2);
      if (tb_cyc == 300) checkOutput("page wrap @300", page_idx, 0);
      if (frame_done && tb_cyc >= 235 && seen == 0) begin
        seen = 1;
        checkOutput("auto page2 line1", line1_buffer, "CH4: C0DE       ");
        checkOutput("auto page2 line2", line2_buffer, BLANK);
      end
    end
    checkOutput("auto page2 frame seen", seen, 1);

    // Snapshot and coalescing during the startup render
    freeze = 1'b1;
    startFromReset();
    repeat (10) tick();
    ch_values[15:0] = 16'h7777;
    page_next = 1'b1; tick();
    page_next = 1'b0; tick();
    page_next = 1'b1; tick();
    page_next = 1'b0;
    checkOutput("coalesce page_idx", page_idx, 2);
    waitFrame(40, took);
    checkOutput("coalesce first frame cycle", tb_cyc, 35);
    checkOutput("snapshot line1", line1_buffer, "CH0: 1A2F       ");
    checkOutput("snapshot line2", line2_buffer, "CH1: 00B3       ");
    waitFrame(45, took);
    checkOutput("coalesce frame spacing", took, 35);
    checkOutput("coalesce line1", line1_buffer, "CH4: C0DE       ");
    checkOutput("coalesce line2", line2_buffer, BLANK);
    fd_count = 0;
    repeat (100) begin
      tick();
      if (frame_done) fd_count++;
    end
    checkOutput("coalesce extra frames", fd_count, 0);

    // Table-driven page/format vectors
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      waitFrame(40, took);
      checkOutput($sformatf("vec%0d latency", i), took, 35);
      checkOutput($sformatf("vec%0d page_idx", i), page_idx, vecs[i].page);
      checkOutput($sformatf("vec%0d line1", i), line1_buffer, vecs[i].l1);
      checkOutput($sformatf("vec%0d line2", i), line2_buffer, vecs[i].l2);
    end

    // Freeze holds the page and suppresses refresh; page_next still works
    fd_count = 0;
    repeat (500) begin
      tick();
      if (frame_done) fd_count++;
    end
    checkOutput("freeze frames", fd_count, 0);
    checkOutput("freeze page_idx", page_idx, 2);
    page_next = 1'b1; tick();
    page_next = 1'b0;
    waitFrame(40, took);
    checkOutput("freeze page_next latency", took, 35);
    checkOutput("freeze page_next page", page_idx, 0);
    checkOutput("freeze page_next line1", line1_buffer, "CH0: 2468       ");
    checkOutput("freeze page_next line2", line2_buffer, "CH1: ACE1       ");

    // Reset in the middle of a render
    page_next = 1'b1; tick();
    page_next = 1'b0;
    repeat (11) tick();
    checkOutput("midrender busy before reset", busy, 1);
    rst = 1'b1;
    tick();
    checkOutput("midrender reset busy", busy, 0);
    checkOutput("midrender reset frame_done", frame_done, 0);
    checkOutput("midrender reset line1", line1_buffer, BLANK);
    checkOutput("midrender reset line2", line2_buffer, BLANK);
    checkOutput("midrender reset page_idx", page_idx, 0);
    repeat (2) tick();
    rst    = 1'b0;
    tb_cyc = 0;
    waitFrame(40, took);
    checkOutput("rerender latency", took, 35);
    checkOutput("rerender line1", line1_buffer, "CH0: 2468       ");
    checkOutput("rerender line2", line2_buffer, "CH1: ACE1       ");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
